// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Handles MULT/MULTU/DIV/DIVU at one bit per cycle, plus MTHI/MTLO, and owns
// the architectural HI/LO registers. busy stalls the front of the pipe while
// an operation is in flight; flush aborts it without touching HI/LO.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   low half holds dividend bits shifting out / quotient bits shifting in.
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   rem_q,   rem_d;
  logic [WIDTH-1:0]   opnd_q,  opnd_d;   // multiplicand or divisor magnitude
  logic               neg_q,   neg_d;    // product / quotient sign
  logic               rneg_q,  rneg_d;   // remainder sign
  logic               is_div_q, is_div_d;
  logic               div0_q,  div0_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic               done_q,  done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_qbit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
    b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;
  end

  // One iteration of shift-add multiply and restoring divide, plus sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_qbit  = (div_shift >= {1'b0, opnd_q});
    // The true difference is below 2^WIDTH whenever it is kept, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    prod_fix  = neg_q  ? -acc_q : acc_q;
    quot_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -rem_q : rem_q;
  end

  // Next-state logic for the IDLE/RUN/FIN sequencer and HI/LO writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              opnd_d   = a_mag;
              neg_d    = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              rneg_d   = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              is_div_d = 1'b0;
              div0_d   = 1'b0;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              neg_d    = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              rneg_d   = is_signed && A[WIDTH-1];
              is_div_d = 1'b1;
              rem_d    = '0;
              cnt_d    = CNT_W'(WIDTH);
              if (B == '0) begin
                // Divide by zero bypasses RUN; the raw dividend is parked for HI.
                div0_d  = 1'b1;
                acc_d   = {{WIDTH{1'b0}}, A};
                state_d = S_FIN;
              end else begin
                div0_d  = 1'b0;
                acc_d   = {{WIDTH{1'b0}}, a_mag};
                opnd_d  = b_mag;
                state_d = S_RUN;
              end
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div_q) begin
            rem_d = div_qbit ? div_diff : div_shift[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_qbit};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (div0_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: an arithmetic reference model with a
// latency countdown is compared against the DUT every cycle, and directed
// cases pin the model to hand-computed values.
module tb_ex_muldiv_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] HI, LO;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  // Reference result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint      sp;
    int          sa, sb;
    logic [W-1:0] q, r;
    p = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'b000: begin sp = longint'(sa) * longint'(sb); p = sp; end
      3'b001: p = {32'b0, a} * {32'b0, b};
      3'b010, 3'b011: begin
        if (b == 0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 3'b010 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          p = {32'h0, 32'h8000_0000};
        end else if (o == 3'b010) begin
          q = sa / sb;
          r = sa % sb;
          p = {r, q};
        end else begin
          q = a / b;
          r = a % b;
          p = {r, q};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Model: architectural HI/LO plus a countdown of cycles until the result lands.
  logic [W-1:0] m_hi, m_lo;
  logic         m_busy, m_done;
  logic [63:0]  m_res;
  int           m_rem;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy <= 1'b0;
          m_rem  <= 0;
        end else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
          end
        end
      end else if (start && !flush) begin
        case (op)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            m_res  <= ref_result(op, A, B);
            m_busy <= 1'b1;
            m_rem  <= (op[1] && B == 0) ? 1 : int'(W) + 1;
          end
          3'b100: m_hi <= A;
          3'b101: m_lo <= A;
          default: ;
        endcase
      end
    end
  end

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op for a single cycle and count cycles (after the accepting edge) until done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(posedge clk); #2;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #2;
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  int lat;
  int d0;
  logic [W-1:0] lo_before;

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #2;
    checkw("rst_hi", HI, 32'h0);
    checkw("rst_lo", LO, 32'h0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    reset = 1'b1;

    fork
      forever begin
        @(negedge clk);
        check1("cyc_busy", busy, m_busy);
        check1("cyc_done", done, m_done);
        checkw("cyc_hi", HI, m_hi);
        checkw("cyc_lo", LO, m_lo);
        if (done) done_cnt = done_cnt + 1;
      end
    join_none

    // MTLO in IDLE
    @(posedge clk); #2;
    start = 1'b1; op = 3'b101; A = 32'h55;
    @(posedge clk); #2;
    start = 1'b0;
    checkw("mtlo_lo", LO, 32'h55);
    check1("mtlo_busy", busy, 1'b0);

    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, lat);
    checkw("mult_lat", lat, 34);
    checkw("mult_hi", HI, 32'hFFFF_FFFF);
    checkw("mult_lo", LO, 32'hFFFF_FFF1);

    run_op(3'b001, 32'hFFFF_FFFD, 32'd5, lat);
    checkw("multu_hi", HI, 32'h0000_0004);
    checkw("multu_lo", LO, 32'hFFFF_FFF1);

    run_op(3'b011, 32'd100, 32'd7, lat);
    checkw("divu_lat", lat, 34);
    checkw("divu_hi", HI, 32'd2);
    checkw("divu_lo", LO, 32'd14);

    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, lat);
    checkw("div_hi", HI, 32'hFFFF_FFFF);
    checkw("div_lo", LO, 32'hFFFF_FFFD);

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checkw("divovf_hi", HI, 32'h0);
    checkw("divovf_lo", LO, 32'h8000_0000);

    run_op(3'b010, 32'h1234, 32'h0, lat);
    checkw("div0_lat", lat, 2);
    checkw("div0_hi", HI, 32'h1234);
    checkw("div0_lo", LO, 32'hFFFF_FFFF);

    // Flush in RUN cycle 10 after preloading HI
    @(posedge clk); #2;
    start = 1'b1; op = 3'b100; A = 32'hAAAA;
    @(posedge clk); #2;
    start = 1'b0;
    checkw("mthi_hi", HI, 32'hAAAA);
    lo_before = LO;
    d0 = done_cnt;
    start = 1'b1; op = 3'b000; A = 32'd123; B = 32'd456;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    check1("flush_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    checkw("flush_nodone", done_cnt - d0, 0);
    checkw("flush_hi", HI, 32'hAAAA);
    checkw("flush_lo", LO, lo_before);

    // start held high through a whole DIVU, operands changing underneath
    d0 = done_cnt;
    @(posedge clk); #2;
    start = 1'b1; op = 3'b011; A = 32'd1000; B = 32'd3;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #2;
      A = 32'($urandom); B = 32'($urandom);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    checkw("hold_one_done", done_cnt - d0, 1);
    checkw("hold_hi", HI, 32'd1);
    checkw("hold_lo", LO, 32'd333);

    // Reset in RUN cycle 5
    @(posedge clk); #2;
    start = 1'b1; op = 3'b000; A = 32'd77; B = 32'd99;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkw("mrst_hi", HI, 32'h0);
    checkw("mrst_lo", LO, 32'h0);
    check1("mrst_busy", busy, 1'b0);
    check1("mrst_done", done, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    run_op(3'b011, 32'd100, 32'd7, lat);
    checkw("post_rst_lat", lat, 34);
    checkw("post_rst_lo", LO, 32'd14);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(3) == 0);
      op    = 3'($urandom_range(7));
      A     = pick();
      B     = pick();
      flush = ($urandom_range(39) == 0);
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
